// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and bit-timing helper
//
// Shared by uart_rx and uart_tx so both ends derive identical bit timing.
//   rx_state_t    : receiver FSM state encoding
//   DATA_BITS     : payload bits per frame (8N1)
//   LINE_IDLE     : level of an idle serial line
//   clks_per_bit(): system clocks per serial bit
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    // Integer division truncates; callers pick frequencies that keep the
    // resulting baud error within the receiver's mid-bit sampling margin.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// rtl/uart_sync_2ff.sv - two-flop synchroniser for asynchronous inputs
//
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset; both stages load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, two cycles behind d
module uart_sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error report
//
// Ports:
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   rx         : asynchronous serial line, idles high
//   dout       : last good received byte, held until the next good frame
//   dout_valid : one-cycle pulse when dout is updated
//   frame_err  : one-cycle pulse when a stop bit samples low
//   rx_busy    : high from start-bit detection until the FSM is back in IDLE
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       LAST_BIT     = 3'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [2:0]           bit_index;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_s;

    uart_sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Once START has confirmed the start bit at its centre, every later
    // sample lands one full bit period on, i.e. in the middle of each bit.
    // The stop bit is therefore judged half a bit early, which gives the
    // FSM time to be back in IDLE before a back-to-back start edge arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_index  <= '0;
            shift_reg  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses unless set below.
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt   <= '0;
                    bit_index <= '0;
                    if (rx_s == 1'b0) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end

                START: begin
                    if (clk_cnt == CNT_HALF_END) begin
                        clk_cnt <= '0;
                        if (rx_s == 1'b0) begin
                            state <= DATA;
                        end else begin
                            // Low pulse shorter than half a bit: noise, not a start.
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == CNT_BIT_END) begin
                        clk_cnt   <= '0;
                        // LSB arrives first, so shifting in at the MSB leaves
                        // bit 0 in shift_reg[0] after the eighth sample.
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_index == LAST_BIT) begin
                            bit_index <= '0;
                            state     <= STOP;
                        end else begin
                            bit_index <= bit_index + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (clk_cnt == CNT_BIT_END) begin
                        clk_cnt <= '0;
                        if (rx_s == 1'b1) begin
                            dout       <= shift_reg;
                            dout_valid <= 1'b1;
                            state      <= IDLE;
                            rx_busy    <= 1'b0;
                        end else begin
                            // Keep the previous dout; the payload is suspect.
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    // A line held low (break) must not be mistaken for a
                    // string of start bits; wait for it to return high.
                    clk_cnt   <= '0;
                    bit_index <= '0;
                    if (rx_s == 1'b1) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    int         ferr_cnt  = 0;
    bit         busy_seen = 0;
    bit         both_high = 0;

    uart_rx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) rx_q.push_back(dout);
            if (frame_err) ferr_cnt++;
            if (rx_busy) busy_seen = 1'b1;
            if (dout_valid && frame_err) both_high = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        ferr_cnt  = 0;
        busy_seen = 1'b0;
    endtask

    logic [7:0] lb_data[16];

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check("reset_valid", dout_valid, 1'b0);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single good byte
        clear_mon();
        send_byte(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        check("a5_count", rx_q.size(), 1);
        check("a5_value", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA5);
        check("a5_dout", dout, 8'hA5);
        check("a5_ferr", ferr_cnt, 0);
        check("a5_busy_after", rx_busy, 1'b0);

        // Back-to-back frames with no idle gap
        clear_mon();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (10) @(negedge clk);
        check("b2b_count", rx_q.size(), 3);
        check("b2b_0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h00);
        check("b2b_1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'hFF);
        check("b2b_2", (rx_q.size() > 2) ? rx_q[2] : 8'hxx, 8'h55);
        check("b2b_ferr", ferr_cnt, 0);

        // Glitch shorter than half a bit
        clear_mon();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_valid", rx_q.size(), 0);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_end", rx_busy, 1'b0);

        // Framing error followed by a break, then recovery
        clear_mon();
        send_byte(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        check("ferr_busy_in_break", rx_busy, 1'b1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_valid", rx_q.size(), 0);
        check("ferr_dout_kept", dout, 8'h55);
        check("ferr_busy_end", rx_busy, 1'b0);
        send_byte(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        check("post_ferr_count", rx_q.size(), 1);
        check("post_ferr_dout", dout, 8'h81);

        // Reset in the middle of the data bits of 0x7E
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h7E >> i));
        check("mid_busy_before_rst", rx_busy, 1'b1);
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_dout", dout, 8'h00);
        check("mid_rst_valid", dout_valid, 1'b0);
        check("mid_rst_ferr", frame_err, 1'b0);
        check("mid_rst_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("mid_rst_no_pulse", rx_q.size(), 0);
        send_byte(8'h12, 1'b1);
        repeat (10) @(negedge clk);
        check("post_rst_count", rx_q.size(), 1);
        check("post_rst_dout", dout, 8'h12);

        // Loopback-style stream of 16 random bytes, back to back
        clear_mon();
        for (int i = 0; i < 16; i++) lb_data[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) send_byte(lb_data[i], 1'b1);
        repeat (10) @(negedge clk);
        check("lb_count", rx_q.size(), 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("lb_byte%0d", i), (rx_q.size() > i) ? rx_q[i] : 8'hxx, lb_data[i]);
        check("lb_ferr", ferr_cnt, 0);

        check("valid_ferr_exclusive", both_high, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
